// File: rtl/n_bit_piso_tx.sv
// Parallel-in/serial-out transmitter: accepts an N-bit word on a valid/ready load and shifts it out MSB-first.
// Optional feature macro: PARITY_EN appends one even-parity bit to every frame.
module n_bit_piso_tx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] D,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef PARITY_EN
        PAR   = 2'd2,
`endif
        SHIFT = 2'd1
    } state_t;

    state_t         state_reg;
    logic [N-1:0]   shreg_reg;
    logic [CW-1:0]  cnt_reg;
    logic [N-1:0]   shreg_shift;
`ifdef PARITY_EN
    logic           parity_reg;
`endif

    assign load_ready  = (state_reg == IDLE);
    assign shreg_shift = shreg_reg << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        shreg_reg <= D;
                        ser_out   <= D[N-1];
                        ser_valid <= 1'b1;
                        busy      <= 1'b1;
                        cnt_reg   <= CW'(1);
                        state_reg <= SHIFT;
`ifdef PARITY_EN
                        parity_reg <= ^D;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_reg == CW'(N)) begin
                        // Last data bit has been on the line for one cycle.
                        cnt_reg <= '0;
`ifdef PARITY_EN
                        ser_out   <= parity_reg;
                        state_reg <= PAR;
`else
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= IDLE;
`endif
                    end else begin
                        shreg_reg <= shreg_shift;
                        ser_out   <= shreg_shift[N-1];
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
`ifdef PARITY_EN
                PAR: begin
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_n_bit_piso_tx.sv
// Directed bench for n_bit_piso_tx (N=8): frame contents, back-to-back loads, ignored loads, reset abort.
module tb_n_bit_piso_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] D = 8'h00;
    logic       load_valid = 1'b0;
    logic       load_ready, ser_out, ser_valid, busy, done;

    int total = 0;
    int bad   = 0;

    n_bit_piso_tx #(.N(8)) dut (
        .clk(clk), .reset(reset), .D(D), .load_valid(load_valid),
        .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Sends w; exp_bits is the hand-written MSB-first sequence, exp_par the hand-computed parity.
    task automatic run_frame(input string name, input logic [7:0] w, input logic [7:0] exp_bits,
                             input logic exp_par, input bit poke);
        @(negedge clk);
        check_val({name, " load_ready"}, load_ready, 1);
        D = w;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        D = ~w;
        for (int i = 0; i < 8; i++) begin
            if (poke && i == 3) begin
                D = 8'hFF;
                load_valid = 1'b1;
            end
            if (poke && i == 4) load_valid = 1'b0;
            check_val($sformatf("%s bit%0d", name, i), {ser_valid, busy, done, load_ready, ser_out},
                      {4'b1100, exp_bits[7-i]});
            @(negedge clk);
        end
`ifdef PARITY_EN
        check_val({name, " parity"}, {ser_valid, busy, done, ser_out}, {3'b110, exp_par});
        @(negedge clk);
`else
        if (exp_par === 1'bx) $display("unused parity");
`endif
        check_val({name, " done"}, {done, ser_valid, busy, load_ready}, 4'b1001);
        @(negedge clk);
        check_val({name, " done_drop"}, {done, busy}, 2'b00);
    endtask

    initial begin
        // 1. reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("reset outs", {ser_out, ser_valid, busy, done, load_ready}, 5'b00001);

        // 2/3. frames, including D changing after capture
        run_frame("A5", 8'hA5, 8'b1010_0101, 1'b0, 1'b0);
        run_frame("07", 8'h07, 8'b0000_0111, 1'b1, 1'b0);
        // 5. load attempt mid-frame ignored
        run_frame("3C_poke", 8'h3C, 8'b0011_1100, 1'b0, 1'b1);

        // 4. back-to-back: F0 then 0F accepted in done cycle
        @(negedge clk);
        D = 8'hF0;
        load_valid = 1'b1;
        @(negedge clk);
        D = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("F0 bit%0d", i), {ser_valid, load_ready, ser_out},
                      {2'b10, (i < 4) ? 1'b1 : 1'b0});
            @(negedge clk);
        end
`ifdef PARITY_EN
        check_val("F0 parity", {ser_valid, ser_out}, 2'b10);
        @(negedge clk);
`endif
        check_val("F0 done", {done, ser_valid, load_ready}, 3'b101);
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("0F bit%0d", i), {ser_valid, busy, done, ser_out},
                      {3'b110, (i < 4) ? 1'b0 : 1'b1});
            @(negedge clk);
        end
`ifdef PARITY_EN
        check_val("0F parity", {ser_valid, ser_out}, 2'b10);
        @(negedge clk);
`endif
        check_val("0F done", {done, busy}, 2'b10);

        // 6. reset at bit 4 of AA
        @(negedge clk);
        D = 8'hAA;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("AA bit%0d", i), {ser_valid, ser_out}, {1'b1, (i % 2 == 0) ? 1'b1 : 1'b0});
            @(negedge clk);
        end
        check_val("AA bit4", {ser_valid, ser_out}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort outs", {ser_out, ser_valid, busy, done, load_ready}, 5'b00001);
        @(negedge clk);
        check_val("abort no done", {ser_valid, busy, done}, 3'b000);

        // reset and load at the same edge: word dropped
        reset = 1'b1;
        load_valid = 1'b1;
        D = 8'h55;
        @(negedge clk);
        reset = 1'b0;
        load_valid = 1'b0;
        check_val("rst+load", {ser_valid, busy, load_ready}, 3'b001);
        @(negedge clk);
        check_val("rst+load after", {ser_valid, busy, done}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
